// File: rtl/jump_ctrl_if.sv
// Jump motion handshake between the sprite position block (master) and
// the jump motion generator (slave).
interface jump_ctrl_if;
  logic              jump_en;
  logic              head_hit;
  logic [31:0]       keycode;
  logic signed [9:0] jump_x_motion;
  logic signed [9:0] jump_y_motion;
  logic              airborne;
  logic [2:0]        jump_state;

  modport master (
    output jump_en, head_hit, keycode,
    input  jump_x_motion, jump_y_motion, airborne, jump_state
  );

  modport slave (
    input  jump_en, head_hit, keycode,
    output jump_x_motion, jump_y_motion, airborne, jump_state
  );
endinterface

// File: rtl/jump_ctrl.sv
// Frame-rate jump generator: gravity-shaped rise, apex and fall that lands
// exactly at takeoff height, then waits for key release before re-arming.
module jump_ctrl #(
  parameter int V0       = 8,
  parameter int GRAV_DIV = 2,
  parameter int MAX_FALL = 8,
  parameter int AIR_X    = 1
) (
  input logic         Clk,
  input logic         Reset_n,
  input logic         frame_tick,
  jump_ctrl_if.slave  jif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RISE = 3'd1,
    APEX = 3'd2,
    FALL = 3'd3,
    LAND = 3'd4
  } state_t;

  localparam logic [3:0]        V0_L       = 4'(V0);
  localparam logic [3:0]        MAX_FALL_L = 4'(MAX_FALL);
  localparam logic [1:0]        GCNT_TOP   = 2'(GRAV_DIV - 1);
  localparam logic signed [9:0] AIR_X_L    = 10'(AIR_X);

  state_t            state, state_nxt;
  logic [3:0]        vel, vel_nxt;
  logic [1:0]        gcnt, gcnt_nxt;
  logic [9:0]        height, height_nxt;
  logic signed [9:0] dir, dir_nxt;
  logic signed [9:0] x_mot, x_nxt;
  logic signed [9:0] y_mot, y_nxt;
  logic              airb, airb_nxt;
  logic              grav_step;
  logic [9:0]        fall_d;

  // A and D together cancel; either one alone picks the air direction.
  function automatic logic signed [9:0] key_dir(input logic [31:0] kc);
    logic has_a;
    logic has_d;
    has_a = 1'b0;
    has_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kc[8*i +: 8] == 8'h04) has_a = 1'b1;
      if (kc[8*i +: 8] == 8'h07) has_d = 1'b1;
    end
    if (has_a && !has_d)      key_dir = -AIR_X_L;
    else if (has_d && !has_a) key_dir = AIR_X_L;
    else                      key_dir = '0;
  endfunction

  function automatic logic [9:0] min_step(input logic [3:0] v, input logic [9:0] h);
    logic [9:0] v_ext;
    v_ext    = {6'd0, v};
    min_step = (v_ext < h) ? v_ext : h;
  endfunction

  function automatic logic [3:0] sat_fall(input logic [3:0] v);
    logic [4:0] inc;
    inc      = {1'b0, v} + 5'd1;
    sat_fall = (inc > {1'b0, MAX_FALL_L}) ? MAX_FALL_L : inc[3:0];
  endfunction

  assign grav_step = (gcnt == GCNT_TOP);
  // Clamping the last fall step to the remaining height forces a zero net Y.
  assign fall_d    = min_step(vel, height);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      vel    <= '0;
      gcnt   <= '0;
      height <= '0;
      dir    <= '0;
      x_mot  <= '0;
      y_mot  <= '0;
      airb   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vel    <= vel_nxt;
      gcnt   <= gcnt_nxt;
      height <= height_nxt;
      dir    <= dir_nxt;
      x_mot  <= x_nxt;
      y_mot  <= y_nxt;
      airb   <= airb_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    vel_nxt    = vel;
    gcnt_nxt   = gcnt;
    height_nxt = height;
    dir_nxt    = dir;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (jif.jump_en) begin
            state_nxt  = RISE;
            vel_nxt    = V0_L;
            gcnt_nxt   = '0;
            height_nxt = '0;
            dir_nxt    = key_dir(jif.keycode);
          end
        end
        RISE: begin
          if (jif.head_hit) begin
            state_nxt = FALL;
            vel_nxt   = 4'd1;
            gcnt_nxt  = '0;
          end else begin
            height_nxt = height + {6'd0, vel};
            gcnt_nxt   = grav_step ? 2'd0 : gcnt + 2'd1;
            if (grav_step) begin
              if (vel == 4'd1) state_nxt = APEX;
              else             vel_nxt   = vel - 4'd1;
            end
          end
        end
        APEX: begin
          state_nxt = FALL;
          vel_nxt   = 4'd1;
          gcnt_nxt  = '0;
        end
        FALL: begin
          height_nxt = height - fall_d;
          gcnt_nxt   = grav_step ? 2'd0 : gcnt + 2'd1;
          if (grav_step) vel_nxt = sat_fall(vel);
          if (height == fall_d) state_nxt = LAND;
        end
        LAND: begin
          if (!jif.jump_en) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output values are captured with the state they lead into.
  always_comb begin
    y_nxt    = y_mot;
    x_nxt    = x_mot;
    airb_nxt = airb;
    if (frame_tick) begin
      y_nxt = '0;
      unique case (state)
        RISE:    if (!jif.head_hit) y_nxt = -$signed({6'd0, vel});
        FALL:    y_nxt = $signed(fall_d);
        default: y_nxt = '0;
      endcase
      airb_nxt = (state_nxt == RISE) || (state_nxt == APEX) || (state_nxt == FALL);
      x_nxt    = airb_nxt ? dir_nxt : 10'sd0;
    end
  end

  assign jif.jump_x_motion = x_mot;
  assign jif.jump_y_motion = y_mot;
  assign jif.airborne      = airb;
  assign jif.jump_state    = state;

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios plus random play, compared tick by
// tick against a trajectory-plan reference model.
module tb_jump_ctrl;

  localparam int V0       = 8;
  localparam int GRAV_DIV = 2;
  localparam int MAX_FALL = 8;
  localparam int AIR_X    = 1;

  localparam int S_IDLE = 0, S_RISE = 1, S_APEX = 2, S_FALL = 3, S_LAND = 4;

  logic Clk;
  logic Reset_n;
  logic frame_tick;

  jump_ctrl_if jif ();

  jump_ctrl #(
    .V0(V0), .GRAV_DIV(GRAV_DIV), .MAX_FALL(MAX_FALL), .AIR_X(AIR_X)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .jif(jif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int st; int y; } step_t;
  step_t plan[$];
  int    rise_left;
  int    climbed;
  int    m_dir;
  bit    landed;
  int    exp_st, exp_y, exp_x, exp_air;

  logic [31:0] key_tab [6];
  int ysum, air_cnt, x_cnt, fall_sum, takeoffs, prev_st;
  bit apex_seen, land_seen;

  function automatic int kdir(input logic [31:0] kc);
    bit a, d;
    logic [7:0] b;
    a = 0; d = 0;
    for (int i = 0; i < 4; i++) begin
      b = kc[8*i +: 8];
      if (b == 8'h04) a = 1;
      if (b == 8'h07) d = 1;
    end
    if (a && !d) return -AIR_X;
    if (d && !a) return AIR_X;
    return 0;
  endfunction

  // Fall from height h: speed starts at 1, grows every GRAV_DIV frames up to
  // MAX_FALL, last step trimmed to what is left.
  function automatic void push_fall(input int h);
    int v, frames, d;
    step_t s;
    v = 1; frames = 0;
    if (h == 0) begin
      s.st = S_LAND; s.y = 0; plan.push_back(s);
      return;
    end
    while (h > 0) begin
      d = (v < h) ? v : h;
      h -= d;
      s.st = (h == 0) ? S_LAND : S_FALL;
      s.y = d;
      plan.push_back(s);
      frames++;
      if (frames % GRAV_DIV == 0 && v < MAX_FALL) v++;
    end
  endfunction

  function automatic void plan_jump();
    step_t s;
    for (int k = 0; k < GRAV_DIV*V0; k++) begin
      s.y  = -(V0 - k / GRAV_DIV);
      s.st = (k == GRAV_DIV*V0 - 1) ? S_APEX : S_RISE;
      plan.push_back(s);
    end
    s.st = S_FALL; s.y = 0;
    plan.push_back(s);
    push_fall(GRAV_DIV * V0 * (V0 + 1) / 2);
    rise_left = GRAV_DIV * V0;
    climbed = 0;
  endfunction

  function automatic void model_reset();
    plan.delete();
    rise_left = 0; climbed = 0; m_dir = 0; landed = 0;
    exp_st = S_IDLE; exp_y = 0; exp_x = 0; exp_air = 0;
  endfunction

  function automatic void model_step(input bit je, input bit hh, input logic [31:0] kc);
    step_t s;
    if (plan.size() == 0) begin
      exp_y = 0;
      if (landed) begin
        exp_st = je ? S_LAND : S_IDLE;
        if (!je) landed = 0;
      end else if (je) begin
        plan_jump();
        m_dir = kdir(kc);
        exp_st = S_RISE;
      end else begin
        exp_st = S_IDLE;
      end
    end else if (rise_left > 0 && hh) begin
      plan.delete();
      rise_left = 0;
      exp_st = S_FALL; exp_y = 0;
      push_fall(climbed);
    end else begin
      s = plan.pop_front();
      exp_st = s.st; exp_y = s.y;
      if (rise_left > 0) begin
        climbed -= s.y;
        rise_left--;
      end
      if (s.st == S_LAND) landed = 1;
    end
    exp_air = (exp_st == S_RISE || exp_st == S_APEX || exp_st == S_FALL) ? 1 : 0;
    exp_x   = exp_air ? m_dir : 0;
  endfunction

  task automatic check_all(input string tag);
    logic signed [9:0] ey, ex;
    ey = 10'(exp_y);
    ex = 10'(exp_x);
    checks++;
    assert (jif.jump_state === 3'(exp_st)) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, jif.jump_state, exp_st);
    end
    checks++;
    assert (jif.jump_y_motion === ey) else begin
      errors++;
      $error("FAIL %s y: got %0d want %0d", tag, jif.jump_y_motion, ey);
    end
    checks++;
    assert (jif.jump_x_motion === ex) else begin
      errors++;
      $error("FAIL %s x: got %0d want %0d", tag, jif.jump_x_motion, ex);
    end
    checks++;
    assert (jif.airborne === exp_air[0]) else begin
      errors++;
      $error("FAIL %s airborne: got %0b want %0b", tag, jif.airborne, exp_air[0]);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Non-tick cycles with random request/hit levels: nothing may move.
  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      jif.jump_en  = 1'($urandom_range(0, 1));
      jif.head_hit = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      check_all("gap");
    end
  endtask

  task automatic do_tick(input bit je, input bit hh, input logic [31:0] kc, input string tag);
    gap_cycles($urandom_range(0, 2));
    jif.jump_en = je; jif.head_hit = hh; jif.keycode = kc;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    jif.jump_en = 1'b0; jif.head_hit = 1'b0;
    model_step(je, hh, kc);
    check_all(tag);
    ysum += int'(jif.jump_y_motion);
    if (jif.airborne) air_cnt++;
    if (jif.jump_x_motion == 10'sd1) x_cnt++;
    if (jif.jump_state == 3'd2) apex_seen = 1;
    if (jif.jump_state == 3'd4) land_seen = 1;
    if (jif.jump_y_motion > 0) fall_sum += int'(jif.jump_y_motion);
    if (prev_st != S_RISE && jif.jump_state == 3'd1) takeoffs++;
    prev_st = int'(jif.jump_state);
  endtask

  task automatic clear_stats();
    ysum = 0; air_cnt = 0; x_cnt = 0; fall_sum = 0; takeoffs = 0;
    apex_seen = 0; land_seen = 0;
  endtask

  initial begin
    key_tab[0] = 32'h0000_0000;
    key_tab[1] = 32'h0000_0004;
    key_tab[2] = 32'h0000_071A;
    key_tab[3] = 32'h0000_0704;
    key_tab[4] = 32'h0700_1600;
    key_tab[5] = 32'h0004_0404;
    prev_st = S_IDLE;
    clear_stats();

    Reset_n = 1'b1; frame_tick = 1'b0;
    jif.jump_en = 1'b0; jif.head_hit = 1'b0; jif.keycode = '0;
    #1 Reset_n = 1'b0;
    model_reset();
    repeat (2) begin @(posedge Clk); #1; check_all("reset"); end
    frame_tick = 1'b1; jif.jump_en = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0; jif.jump_en = 1'b0;
    check_all("reset_tick");
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_all("post_reset");

    // Default jump, no direction keys.
    clear_stats();
    do_tick(1, 0, 32'h0, "default_takeoff");
    check_int("takeoff_y_zero", int'(jif.jump_y_motion), 0);
    for (int i = 0; i < 40; i++) do_tick(0, 0, 32'h0, "default");
    check_int("default_ysum", ysum, 0);
    check_int("default_airtime", air_cnt, 33);
    check_int("default_final_idle", int'(jif.jump_state), S_IDLE);

    // Directional jump; mid-air key change must not matter.
    clear_stats();
    do_tick(1, 0, 32'h0000_071A, "dir_takeoff");
    for (int i = 0; i < 10; i++) do_tick(0, 0, 32'h0000_071A, "dir");
    for (int i = 0; i < 30; i++) do_tick(0, 0, 32'h0000_0004, "dir_chg");
    check_int("dir_x_plus_ticks", x_cnt, 33);

    clear_stats();
    do_tick(1, 0, 32'h0000_0704, "dir_both_takeoff");
    for (int i = 0; i < 40; i++) do_tick(0, 0, 32'h0000_0004, "dir_both");
    check_int("dir_both_x_plus_ticks", x_cnt, 0);

    // Head hit on the third rise tick.
    clear_stats();
    do_tick(1, 0, 32'h0, "hit_takeoff");
    do_tick(0, 0, 32'h0, "hit_r1");
    do_tick(0, 0, 32'h0, "hit_r2");
    do_tick(0, 1, 32'h0, "hit_r3");
    for (int i = 0; i < 20; i++) do_tick(0, 1'($urandom_range(0, 1)), 32'h0, "hit_fall");
    check_int("hit_no_apex", int'(apex_seen), 0);
    check_int("hit_land_seen", int'(land_seen), 1);
    check_int("hit_fall_sum", fall_sum, 16);
    check_int("hit_ysum", ysum, 0);

    // Held key: one jump only, released from LAND one tick after release.
    clear_stats();
    for (int i = 0; i < 100; i++) do_tick(1, 0, 32'h0, "held");
    check_int("held_one_takeoff", takeoffs, 1);
    check_int("held_in_land", int'(jif.jump_state), S_LAND);
    do_tick(0, 0, 32'h0, "release");
    check_int("release_idle", int'(jif.jump_state), S_IDLE);
    do_tick(1, 0, 32'h0, "second_press");
    check_int("second_rise", int'(jif.jump_state), S_RISE);

    // Reset asynchronously during the fall.
    for (int i = 0; i < 24; i++) do_tick(0, 0, 32'h0, "pre_reset");
    check_int("pre_reset_fall", int'(jif.jump_state), S_FALL);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    prev_st = S_IDLE;
    for (int i = 0; i < 5; i++) do_tick(0, 0, 32'h0, "after_reset");

    // Random play.
    for (int i = 0; i < 400; i++)
      do_tick($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
              key_tab[$urandom_range(0, 5)], "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Frame-rate jump motion generator for the player sprite. It is the responder side of the `jump_en` / `jump_x_motion` / `jump_y_motion` interface: the sprite position block raises `jump_en` from keyboard decode and adds the returned motion words to its X/Y position once per frame. The block sequences a gravity-shaped rise, apex and fall that returns exactly to takeoff height. It then waits for key release before another jump is allowed.

## Interface
- `V0`, 8: initial upward speed, px/frame (1..15).
- `GRAV_DIV`, 2: frames per 1 px/frame velocity change (1..4).
- `MAX_FALL`, 8: fall speed cap, px/frame (1..15).
- `AIR_X`, 1: horizontal air speed, px/frame.
- Constraint: `GRAV_DIV*V0*(V0+1)/2 <= 1023`.

- `Clk`  in  1  system clock; the only clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-`Clk` pulse per video frame; all state advances only on cycles where it is high.
- `jump_en`  in  1  jump request level.
- `head_hit`  in  1  ceiling contact; sampled on ticks.
- `keycode`  in  32  four packed HID usage bytes; `0x04` means A, `0x07` means D.
- `jump_x_motion`  out  10  two's-complement X delta for the current frame.
- `jump_y_motion`  out  10  two's-complement Y delta for the current frame; up is negative.
- `airborne`  out  1  high in RISE, APEX and FALL.
- `jump_state`  out  3  state encoding: IDLE=0, RISE=1, APEX=2, FALL=3, LAND=4.

## Operation
- Internal registers:
  - `vel`: 4 bits, unsigned.
  - `gcnt`: 2 bits, gravity frame counter.
  - `height`: 10 bits, unsigned px above takeoff.
  - `dir`: 10 bits, signed.
- Gravity step: on a tick, if `gcnt==GRAV_DIV-1` then `gcnt<=0` and the velocity step applies; otherwise `gcnt<=gcnt+1`.
- IDLE
  - Outputs are 0.
  - Tick with `jump_en=1` goes to RISE with `vel=V0`, `gcnt=0`, `height=0`, and `dir` latched from `keycode`.
  - Direction latch: any byte `0x04` and no byte `0x07` gives `-AIR_X`; `0x07` only gives `+AIR_X`; otherwise 0.
- RISE, per tick
  - If `head_hit`: `y=0`, go to FALL with `vel=1`, `gcnt=0`.
  - Otherwise: `y=-vel`, `height+=vel`, gravity step.
  - Velocity step in RISE: if `vel==1` go to APEX, else `vel-=1`.
- APEX: one tick with `y=0`, then FALL with `vel=1`, `gcnt=0`.
- FALL, per tick
  - `d=min(vel,height)`; `y=+d`; `height-=d`.
  - Velocity step in FALL: `vel=min(vel+1,MAX_FALL)`.
  - If `height-d==0`, go to LAND.
  - A zero-height entry (head hit on the first RISE tick) emits `y=0` and goes to LAND.
- LAND
  - Outputs are 0.
  - Tick with `jump_en=0` goes to IDLE; while `jump_en` stays held the block remains in LAND, so a held key never auto-repeats.
- `jump_x_motion=dir` in RISE, APEX and FALL, 0 otherwise. `dir` is held for the whole jump; `keycode` changes in the air are ignored.
- `head_hit` is ignored outside RISE. `keycode` is ignored outside the IDLE takeoff tick.
- Net Y displacement over any completed jump is exactly 0.

## Timing
- All outputs are registered and update only on the `Clk` edge of a `frame_tick` cycle; they are held between ticks.
- Reset value of every output and register is 0; state is IDLE.
- `Reset_n` low mid-jump returns to IDLE with zero outputs immediately (asynchronously). Ticks during reset are ignored.
- Takeoff latency: the first nonzero `jump_y_motion` appears on the tick after the one that sampled `jump_en=1`.
- Default airtime (V0=8, GRAV_DIV=2, MAX_FALL=8): 16 RISE ticks (8,8,7,7,…,1,1; apex height 72), 1 APEX tick, 16 FALL ticks (1,1,2,2,…,7,7,8,8).
- `jump_en` and `head_hit` arriving on non-tick cycles are not latched; only their level at a tick matters.

## Test plan
- Default jump:
  - Stimulus: `jump_en` pulsed high for one tick in IDLE, `keycode=0`.
  - Y sequence: 0, then −8,−8,−7,…,−1,−1, 0, +1,+1,…,+8,+8.
  - State goes to LAND then IDLE, the Y sum is 0, `airborne` is high for exactly 33 ticks, and X is 0 throughout.
- Directional jump:
  - Stimulus: `keycode=0x0000071A` at takeoff, changed to `0x04` mid-air.
  - `jump_x_motion=+1` (`10'h001`) for all 33 airborne ticks.
  - With `keycode=0x0704`, X is 0.
- Head hit:
  - Stimulus: `head_hit` on the 3rd RISE tick.
  - Y sequence: −8,−8, 0, then falls +1,+1,+2,+2,… with the last step clamped, totalling 16.
  - Ends in LAND with no APEX state observed.
- Held key:
  - Stimulus: `jump_en` held high for 100 ticks.
  - Exactly one jump occurs, the block stays in LAND, and it returns to IDLE one tick after release.
  - A new press then starts a second jump.
- Reset mid-fall:
  - Stimulus: `Reset_n` driven low between ticks during FALL.
  - Outputs go to 0 and state to IDLE without waiting for `Clk`.
  - After release, ticks with `jump_en=0` keep all outputs at 0.
- Tick gating:
  - Stimulus: `jump_en` pulses only on non-tick cycles.
  - No state change occurs.
